// File: rtl/digit_stat_engine_if.sv
// Digit-stream statistics bus: digit stream plus mode word in,
// one registered result pulse out.
interface digit_stat_engine_if #(
  parameter int OUT_W = 11
);
  logic [3:0]       in;
  logic             in_valid;
  logic [1:0]       mode;
  logic [OUT_W-1:0] out;
  logic             out_valid;

  modport master (
    output in, in_valid, mode,
    input  out, out_valid
  );

  modport slave (
    input  in, in_valid, mode,
    output out, out_valid
  );
endinterface

// File: rtl/digit_stat_engine.sv
// Counts digits 1..NUM_DIG until a 0 terminator, then reduces the
// counters to max, min or digit-weighted sum selected by a mode word.
module digit_stat_engine #(
  parameter int NUM_DIG = 9,
  parameter int CNT_W   = 5,
  parameter int OUT_W   = 11
)(
  input logic               clk,
  input logic               rst,
  digit_stat_engine_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_DIG + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ACCUM,
    MODE,
    CALC,
    DONE
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       mode_q;
  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] acc_d;
  logic [OUT_W-1:0] cur;
  logic [OUT_W-1:0] out_q;
  logic             ov_q;
  logic             calc_last;
  logic [CNT_W-1:0] cnt_q [NUM_DIG];

  // one extra CALC cycle after the last counter latches the result
  assign calc_last = (idx_q == IDX_W'(NUM_DIG));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM: if (bus.in_valid && bus.in == 4'd0)
               state_d = MODE;
      MODE:  state_d = CALC;
      CALC:  if (calc_last) state_d = DONE;
      DONE:  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_DIG; i++)
      if (idx_q == IDX_W'(i))
        cur = OUT_W'(cnt_q[i]);
  end

  always_comb begin
    acc_d = acc_q;
    unique case (mode_q)
      2'd0: acc_d = (cur > acc_q) ? cur : acc_q;
      2'd1: acc_d = (cur < acc_q) ? cur : acc_q;
      2'd2: acc_d = acc_q
                  + (OUT_W'(idx_q) + OUT_W'(1)) * cur;
      2'd3: acc_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIG; i++)
        cnt_q[i] <= '0;
      idx_q  <= '0;
      mode_q <= 2'd0;
      acc_q  <= '0;
      out_q  <= '0;
      ov_q   <= 1'b0;
    end else begin
      out_q <= '0;
      ov_q  <= 1'b0;
      unique case (state_q)
        ACCUM: begin
          for (int i = 0; i < NUM_DIG; i++)
            if (bus.in_valid
                && bus.in == 4'(i + 1)
                && cnt_q[i] != CNT_MAX)
              cnt_q[i] <= cnt_q[i] + 1'b1;
        end
        MODE: begin
          mode_q <= bus.mode;
          idx_q  <= '0;
          acc_q  <= (bus.mode == 2'd1)
                  ? OUT_W'(CNT_MAX) : '0;
        end
        CALC: begin
          if (calc_last) begin
            out_q <= acc_q;
            ov_q  <= 1'b1;
          end else begin
            acc_q <= acc_d;
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          for (int i = 0; i < NUM_DIG; i++)
            cnt_q[i] <= '0;
          acc_q <= '0;
          idx_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = ov_q;

endmodule

// File: tb/tb_digit_stat_engine.sv
// Bench for digit_stat_engine: directed cases plus random streams
// scored against a counting reference model.
module tb_digit_stat_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_ov = 1'b0;

  always #5 clk = ~clk;

  digit_stat_engine_if #(.OUT_W(11)) bus();

  digit_stat_engine #(
    .NUM_DIG(9),
    .CNT_W(5),
    .OUT_W(11)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.out_valid)
        chk("out_idle", 32'(bus.out), 0);
      if (bus.out_valid)
        chk("pulse_width", 32'(prev_ov), 0);
    end
    prev_ov = rst ? 1'b0 : bus.out_valid;
  end

  function automatic int model(input logic [3:0] s[$],
                               input logic [1:0] md);
    int c[9];
    int r;
    foreach (c[i]) c[i] = 0;
    foreach (s[i])
      if (s[i] >= 1 && s[i] <= 9)
        if (c[s[i]-1] < 31) c[s[i]-1]++;
    case (md)
      2'd0: begin
        r = 0;
        foreach (c[i]) if (c[i] > r) r = c[i];
      end
      2'd1: begin
        r = 31;
        foreach (c[i]) if (c[i] < r) r = c[i];
      end
      2'd2: begin
        r = 0;
        foreach (c[i]) r += (i + 1) * c[i];
      end
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic send_digits(input logic [3:0] s[$],
                             input int max_gap);
    foreach (s[i]) begin
      repeat ($urandom_range(0, max_gap)) begin
        bus.in_valid = 1'b0;
        bus.in = 4'($urandom);
        @(posedge clk); #1;
      end
      bus.in = s[i];
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_term(input logic [1:0] md);
    bus.in = 4'd0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.mode = md;
    @(posedge clk); #1;
    bus.mode = 2'($urandom);
  endtask

  task automatic run_stream(input string tag,
                            input logic [3:0] s[$],
                            input logic [1:0] md,
                            input int max_gap,
                            input int exp);
    int k;
    send_digits(s, max_gap);
    send_term(md);
    k = 1;
    while (k <= 20) begin
      @(posedge clk); #1;
      if (bus.out_valid) break;
      bus.in = 4'($urandom);
      bus.in_valid = 1'($urandom);
      k++;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_lat"}, 32'(k), 10);
    chk({tag, "_val"}, 32'(bus.out), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] q[$];
    bus.in = 4'd0;
    bus.in_valid = 1'b0;
    bus.mode = 2'd0;

    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_out", 32'(bus.out), 0);
    chk("rst_ov", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    chk("rst_out2", 32'(bus.out), 0);
    rst = 1'b0;

    q = {};
    for (int d = 1; d <= 9; d++)
      repeat (31) q.push_back(4'(d));
    run_stream("full_sum", q, 2'd2, 19, 1395);

    q = {};
    repeat (40) q.push_back(4'd4);
    repeat (3) q.push_back(4'd7);
    run_stream("max_sat", q, 2'd0, 2, 31);

    q = {};
    for (int d = 1; d <= 9; d++)
      repeat (d == 5 ? 3 : 2) q.push_back(4'(d));
    run_stream("min", q, 2'd1, 3, 2);

    q = {};
    for (int d = 1; d <= 8; d++)
      repeat (2) q.push_back(4'(d));
    run_stream("min_absent", q, 2'd1, 3, 0);

    q = {};
    run_stream("empty_sum", q, 2'd2, 0, 0);
    run_stream("empty_max", q, 2'd0, 0, 0);
    run_stream("empty_min", q, 2'd1, 0, 0);

    q = {};
    q.push_back(4'd3);
    q.push_back(4'd3);
    q.push_back(4'd12);
    q.push_back(4'd9);
    run_stream("ignore12", q, 2'd2, 2, 15);

    run_stream("mode3", q, 2'd3, 2, 0);

    // abandon a stream mid-CALC; the next one must start from zero
    q = {};
    repeat (5) q.push_back(4'd6);
    send_digits(q, 1);
    send_term(2'd2);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("abort_ov", 32'(bus.out_valid), 0);
      @(posedge clk); #1;
    end
    q = {};
    q.push_back(4'd2);
    run_stream("after_abort", q, 2'd2, 1, 2);

    for (int n = 0; n < 1000; n++) begin
      logic [1:0] md;
      int len;
      int r;
      q = {};
      len = $urandom_range(0, 25);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0) q.push_back(4'($urandom_range(10, 15)));
        else        q.push_back(4'(r));
      end
      md = 2'($urandom);
      run_stream("rand", q, md, 2, model(q, md));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/digit_stat_engine.md
Name: digit_stat_engine

Overview:
- Receiving end of the digit-stream statistics interface: accepts a burst-gapped stream of digits 1..9, ended by a 0 terminator, then a one-cycle mode word.
- Returns one statistic on a single-cycle out_valid pulse: max count, min count, or digit-weighted sum.
- Sits directly under the block-level stimulus/checker bench as the DUT for that interface.

Parameters:
- NUM_DIG, 9: number of tracked digit values, 1..NUM_DIG.
- CNT_W, 5: per-digit counter width; counters saturate at 2^CNT_W-1 = 31.
- OUT_W, 11: result width; must hold sum((i)*31, i=1..9) = 1395.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in  input  4  digit; 1..9 = data, 0 = end-of-stream terminator; sampled only when in_valid=1.
- in_valid  input  1  qualifies in; may drop low for any number of cycles between bursts.
- mode  input  2  0=max count, 1=min count, 2=weighted sum, 3=reserved; sampled only in the cycle after the terminator.
- out  output  OUT_W  result; 0 whenever out_valid=0.
- out_valid  output  1  high for exactly one cycle per stream.

Behaviour:
- Reset: sampled on rising clk with rst=1. out=0, out_valid=0, all counters=0, mode register=0, state=ACCUM. Reset mid-stream or mid-calc abandons the stream; no out_valid for it.
- States: ACCUM -> MODE -> CALC -> DONE -> ACCUM.
- ACCUM:
  - in_valid=1, in in 1..9: cnt[in-1] += 1, saturating at 31.
  - in_valid=1, in=0: go to MODE.
  - in_valid=1, in in 10..15: ignored, no count, no transition.
  - in_valid=0: hold.
- MODE: one cycle. Register mode unconditionally and go to CALC. in/in_valid are ignored.
- CALC: NUM_DIG cycles, index j=0..8, one counter per cycle into an accumulator acc.
  - mode 0: acc = max(acc, cnt[j]), acc starts at 0.
  - mode 1: acc = min(acc, cnt[j]), acc starts at 31.
  - mode 2: acc = acc + (j+1)*cnt[j], acc starts at 0, OUT_W-bit unsigned, no overflow possible.
  - mode 3: acc = 0.
  - Go to DONE after j=8.
- DONE: out_valid=1 and out=acc for exactly one cycle, registered. Clear all counters and acc, then go to ACCUM.
- Latency: terminator accepted at edge T; mode sampled at edge T+1; out_valid high in the cycle following edge T+11. Fixed at 10 cycles after mode, which is inside the 100-cycle limit.
- in_valid is ignored outside ACCUM. A new stream may begin in the cycle immediately after the out_valid cycle.
- out_valid is never high while the block is in ACCUM. out is never non-zero when out_valid=0.
- An empty stream (terminator only) gives mode0=0, mode1=0, mode2=0.
- Min includes zero-count digits: any digit never seen gives min=0.

Test Plan:
- Reset check: rst=1 for 2 cycles -> out=0 and out_valid=0 from the first sampled edge. Assert rst during CALC -> no out_valid; the next stream is counted from zero.
- Full-load weighted sum: 31 of each digit 1..9 in order with random gaps of 0-19 cycles, terminator, mode=2 -> out=1395, out_valid for 1 cycle, 10 cycles after mode.
- Max with saturation: 40 samples of digit 4, 3 of digit 7, terminator, mode=0 -> out=31.
- Min: 2 of each digit 1..9 except digit 5 three times, terminator, mode=1 -> out=2. Repeat with digit 9 absent -> out=0.
- Edge cases:
  - Terminator only, mode=2 -> out=0.
  - Stream {3,3,12,9} (12 ignored), mode=2 -> out=15.
  - mode=3 -> out=0, out_valid still pulses once.
- Back-to-back streams: start the next stream the cycle after out_valid. Run 1000 random streams against the bench's reference model -> all match; out_valid never exceeds 1 cycle.
